// File: rtl/biu_arb_pkg.sv
// Shared constants for the BIU arbiter: FSM state encodings, BIU command selects and
// requester ids.
package biu_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] BIU_SEL_FETCH = 2'b00;
    localparam logic [1:0] BIU_SEL_LOAD  = 2'b01;
    localparam logic [1:0] BIU_SEL_STORE = 2'b10;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to the
// requester that was not granted last. Bit 0 is the IFU, bit 1 the LSU.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_id_o,
    output logic       any_o
);

    assign any_o    = |req_i;
    assign gnt_id_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing one BIU between instruction fetch and load/store.
// Define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC cycles without biu_ready.
module biu_arbiter
    import biu_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_done,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req,
    input  logic              lsu_wr,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_done,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              biu_cs,
    output logic [1:0]        biu_sel,
    output logic [ADDR_W-1:0] biu_addr,
    output logic [DATA_W-1:0] biu_wdata,
    input  logic              biu_ready,
    input  logic [DATA_W-1:0] biu_rdata,
    output logic              arb_err,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a requester raises req and holds it (with its command fields) until its
    // one-cycle done pulse; the BIU completes a command by strobing biu_ready with biu_rdata
    // while biu_cs is high, and biu_ready at any other time is ignored.
    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              err_q, err_d;
    logic              pick_id, pick_any;
    logic              timeout;

    rr_pick2 u_pick (
        .req_i    ({lsu_req, ifu_req}),
        .last_i   (last_q),
        .gnt_id_o (pick_id),
        .any_o    (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds the number of BUSY cycles already completed, so the abort lands on the
    // TIMEOUT_CYC-th BUSY cycle.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_BUSY) cnt_d = cnt_q + 1'b1;
    end

    assign timeout = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_id;
                    last_d  = pick_id;
                    state_d = ST_BUSY;
                    if (pick_id == REQ_IFU) begin
                        sel_d   = BIU_SEL_FETCH;
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                    end else begin
                        sel_d   = lsu_wr ? BIU_SEL_STORE : BIU_SEL_LOAD;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wr ? lsu_wdata : '0;
                    end
                end
            end
            ST_BUSY: begin
                if (biu_ready) begin
                    state_d = ST_DONE;
                    if (owner_q == REQ_IFU)          ifu_rdata_d = biu_rdata;
                    else if (sel_q != BIU_SEL_STORE) lsu_rdata_d = biu_rdata;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (owner_q == REQ_IFU) ifu_rdata_d = '0;
                    else                    lsu_rdata_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_IFU;
            last_q      <= REQ_LSU;
            sel_q       <= BIU_SEL_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            err_q       <= err_d;
        end
    end

    assign biu_cs      = (state_q == ST_BUSY);
    assign ifu_gnt     = (state_q != ST_IDLE) && (owner_q == REQ_IFU);
    assign lsu_gnt     = (state_q != ST_IDLE) && (owner_q == REQ_LSU);
    assign ifu_done    = (state_q == ST_DONE) && (owner_q == REQ_IFU);
    assign lsu_done    = (state_q == ST_DONE) && (owner_q == REQ_LSU);
    assign ifu_rdata   = ifu_rdata_q;
    assign lsu_rdata   = lsu_rdata_q;
    assign biu_sel     = sel_q;
    assign biu_addr    = addr_q;
    assign biu_wdata   = wdata_q;
    assign arb_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed bench for biu_arbiter: expected BIU commands and done responses are queued
// as stimulus is issued; a BIU responder and a done monitor pop and compare.
module tb_biu_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [1:0] S_IDLE = 2'd0;

    logic              clk;
    logic              rst_n;
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_done;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req;
    logic              lsu_wr;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_gnt;
    logic              lsu_done;
    logic [DATA_W-1:0] lsu_rdata;
    logic              biu_cs;
    logic [1:0]        biu_sel;
    logic [ADDR_W-1:0] biu_addr;
    logic [DATA_W-1:0] biu_wdata;
    logic              biu_ready;
    logic [DATA_W-1:0] biu_rdata;
    logic              arb_err;
    logic [1:0]        dbg_state;

    // expected BIU command {sel, addr, wdata} and expected done {err, id, rdata}
    logic [49:0] exp_cmd_q[$];
    logic [33:0] exp_q[$];

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;
    int biu_lat = 2;
    logic stray_ready = 1'b0;
    int ifu_more = 0;
    logic [ADDR_W-1:0] ifu_next_addr = '0;

    biu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu_req     (ifu_req),
        .ifu_addr    (ifu_addr),
        .ifu_gnt     (ifu_gnt),
        .ifu_done    (ifu_done),
        .ifu_rdata   (ifu_rdata),
        .lsu_req     (lsu_req),
        .lsu_wr      (lsu_wr),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_gnt     (lsu_gnt),
        .lsu_done    (lsu_done),
        .lsu_rdata   (lsu_rdata),
        .biu_cs      (biu_cs),
        .biu_sel     (biu_sel),
        .biu_addr    (biu_addr),
        .biu_wdata   (biu_wdata),
        .biu_ready   (biu_ready),
        .biu_rdata   (biu_rdata),
        .arb_err     (arb_err),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] sel, input logic [15:0] addr, input logic [31:0] wd);
        exp_cmd_q.push_back({sel, addr, wd});
    endtask

    task automatic push_done(input logic err, input logic id, input logic [31:0] rd);
        exp_q.push_back({err, id, rd});
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_count", 64'(done_cnt >= target), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // BIU responder: checks each new command and answers after biu_lat BUSY cycles (0 = never)
    initial begin : biu_model
        int busy_cnt;
        logic [49:0] e;
        busy_cnt  = 0;
        biu_ready = 1'b0;
        biu_rdata = 32'hBAD0_0000;
        forever begin
            @(negedge clk);
            if (biu_cs) begin
                busy_cnt++;
                if (busy_cnt == 1) begin
                    if (exp_cmd_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL unexpected_cmd: sel=%0d addr=0x%0h", biu_sel, biu_addr);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("biu_cmd", {biu_sel, biu_addr, biu_wdata}, 64'(e));
                        check("owner_gnt", {ifu_gnt, lsu_gnt}, (e[49:48] == 2'b00) ? 2'b10 : 2'b01);
                    end
                end
                if (busy_cnt == biu_lat) begin
                    biu_ready = 1'b1;
                    biu_rdata = 32'hC0DE_0000 | 32'(biu_addr);
                end else begin
                    biu_ready = 1'b0;
                    biu_rdata = 32'hBAD0_0000;
                end
            end else begin
                busy_cnt  = 0;
                biu_ready = stray_ready;
                biu_rdata = 32'hBAD0_0000;
            end
        end
    end

    // scoreboard monitor: pops an expectation on every done pulse, then releases the requester
    initial begin : monitor
        logic [33:0] e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) check("done_single_pulse", 64'(ifu_done | lsu_done), 64'd0);
            if (ifu_done || lsu_done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_done: ifu_done=%0b lsu_done=%0b", ifu_done, lsu_done);
                end else begin
                    e = exp_q.pop_front();
                    check("done_resp", {arb_err, lsu_done, lsu_done ? lsu_rdata : ifu_rdata}, 64'(e));
                end
                done_cnt++;
                if (ifu_done) begin
                    if (ifu_more > 0) begin
                        ifu_more--;
                        ifu_addr = ifu_next_addr;
                    end else begin
                        ifu_req = 1'b0;
                    end
                end
                if (lsu_done) lsu_req = 1'b0;
            end
            prev_done = ifu_done | lsu_done;
        end
    end

    initial begin : main
        int cs_n;
        int done_n;
        int busy_n;
        rst_n     = 1'b0;
        ifu_req   = 1'b0;
        ifu_addr  = '0;
        lsu_req   = 1'b0;
        lsu_wr    = 1'b0;
        lsu_addr  = '0;
        lsu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {biu_cs, ifu_gnt, lsu_gnt, ifu_done, lsu_done, arb_err}, 64'd0);
        check("rst_cmd", {biu_sel, biu_addr, biu_wdata}, 64'd0);
        check("rst_rdata", {ifu_rdata, lsu_rdata}, 64'd0);
        check("rst_state", dbg_state, S_IDLE);

        // tie at reset exit: IFU first, then LSU
        ifu_addr  = 16'h0100;
        lsu_addr  = 16'h0200;
        lsu_wdata = 32'h1111_1111;
        ifu_req   = 1'b1;
        lsu_req   = 1'b1;
        push_cmd(2'b00, 16'h0100, 32'h0);
        push_done(1'b0, 1'b0, 32'hC0DE_0100);
        push_cmd(2'b01, 16'h0200, 32'h0);
        push_done(1'b0, 1'b1, 32'hC0DE_0200);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(2, 60);

        // repeated tie with IFU re-requesting: IFU, LSU, IFU
        ifu_addr      = 16'h0300;
        ifu_next_addr = 16'h0304;
        ifu_more      = 1;
        lsu_addr      = 16'h0400;
        push_cmd(2'b00, 16'h0300, 32'h0);
        push_done(1'b0, 1'b0, 32'hC0DE_0300);
        push_cmd(2'b01, 16'h0400, 32'h0);
        push_done(1'b0, 1'b1, 32'hC0DE_0400);
        push_cmd(2'b00, 16'h0304, 32'h0);
        push_done(1'b0, 1'b0, 32'hC0DE_0304);
        ifu_req = 1'b1;
        lsu_req = 1'b1;
        wait_done(5, 100);

        // single fetch with latency measurement
        biu_lat  = 3;
        ifu_addr = 16'h0040;
        push_cmd(2'b00, 16'h0040, 32'h0);
        push_done(1'b0, 1'b0, 32'hC0DE_0040);
        ifu_req = 1'b1;
        cs_n    = 0;
        done_n  = 0;
        for (int n = 1; n <= 40 && done_n == 0; n++) begin
            @(negedge clk);
            if (biu_cs && cs_n == 0) cs_n = n;
            if (ifu_done) done_n = n;
        end
        check("fetch_cs_latency", 64'(cs_n), 64'd1);
        check("fetch_done_latency", 64'(done_n), 64'd4);
        wait_done(6, 20);

        // load with junk wdata, then store that must not touch lsu_rdata
        biu_lat   = 1;
        lsu_wr    = 1'b0;
        lsu_addr  = 16'h0404;
        lsu_wdata = 32'h5555_AAAA;
        push_cmd(2'b01, 16'h0404, 32'h0);
        push_done(1'b0, 1'b1, 32'hC0DE_0404);
        lsu_req = 1'b1;
        wait_done(7, 40);
        biu_lat   = 2;
        lsu_wr    = 1'b1;
        lsu_addr  = 16'h1234;
        lsu_wdata = 32'hDEAD_BEEF;
        push_cmd(2'b10, 16'h1234, 32'hDEAD_BEEF);
        push_done(1'b0, 1'b1, 32'hC0DE_0404);
        lsu_req = 1'b1;
        wait_done(8, 40);
        lsu_wr = 1'b0;
        check("ifu_rdata_kept", ifu_rdata, 32'hC0DE_0040);

        // stray biu_ready in IDLE, then during a transaction's DONE cycle
        stray_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("stray_idle_state", {dbg_state, biu_cs}, {S_IDLE, 1'b0});
        check("stray_idle_rdata", {ifu_rdata, lsu_rdata}, {32'hC0DE_0040, 32'hC0DE_0404});
        ifu_addr = 16'h0080;
        push_cmd(2'b00, 16'h0080, 32'h0);
        push_done(1'b0, 1'b0, 32'hC0DE_0080);
        ifu_req = 1'b1;
        wait_done(9, 40);
        repeat (3) @(negedge clk);
        stray_ready = 1'b0;
        check("stray_done_count", 64'(done_cnt), 64'd9);
        check("stray_end_state", dbg_state, S_IDLE);

        // reset in the middle of BUSY: transaction dropped, no done
        biu_lat  = 0;
        ifu_addr = 16'h0800;
        push_cmd(2'b00, 16'h0800, 32'h0);
        ifu_req = 1'b1;
        cs_n    = 0;
        for (int n = 1; n <= 20 && cs_n == 0; n++) begin
            @(negedge clk);
            if (biu_cs) cs_n = n;
        end
        check("rstbusy_cs_seen", 64'(cs_n != 0), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstbusy_async", {biu_cs, ifu_gnt, dbg_state}, {1'b0, 1'b0, S_IDLE});
        ifu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstbusy_after", {dbg_state, biu_cs, ifu_rdata}, {S_IDLE, 1'b0, 32'h0});
        check("rstbusy_no_done", 64'(done_cnt), 64'd9);
        biu_lat = 2;

`ifdef ARB_TIMEOUT_EN
        // timeout abort: no biu_ready, four BUSY cycles then done with error and zero data
        biu_lat  = 0;
        lsu_addr = 16'h0900;
        push_cmd(2'b01, 16'h0900, 32'h0);
        push_done(1'b1, 1'b1, 32'h0);
        lsu_req = 1'b1;
        busy_n  = 0;
        done_n  = 0;
        for (int n = 1; n <= 40 && done_n == 0; n++) begin
            @(negedge clk);
            if (biu_cs) busy_n++;
            if (lsu_done) done_n = n;
        end
        check("timeout_busy_cycles", 64'(busy_n), 64'd4);
        wait_done(10, 20);
        biu_lat = 2;
`else
        busy_n = 0;
        done_n = 0;
`endif

        check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
        check("done_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
